// File: rtl/dmem_seq.sv
// Load/store sequencer for the dmem data memory: validates a core request, then
// drives registered rdclk/wrclk pulses around a stable address/op/we setup.
module dmem_seq #(
  parameter int unsigned DMEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_op,
  input  logic        req_we,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_op,
  output logic        mem_we,
  output logic        mem_rdclk,
  output logic        mem_wrclk,
  input  logic [31:0] mem_dataout,
  output logic [15:0] ld_cnt,
  output logic [15:0] st_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, SETUP, RCLK, RHOLD, WCLK, WHOLD, DONE} state_t;

  state_t      state, nxt;
  logic        is_err, is_st;
  logic        accept, req_err, bad_op, bad_align, bad_range;
  logic [15:0] ld_q, st_q, err_q;

  assign accept     = req_valid && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_err   = (state == DONE) && is_err;
  assign ld_cnt     = ld_q;
  assign st_cnt     = st_q;
  assign err_cnt    = err_q;

  // Unsigned extensions (op[2]) have no store form.
  assign bad_op    = (req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_we && req_op[2]);
  assign bad_align = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_op == 3'b010) && (req_addr[1:0] != 2'b00));
  assign bad_range = (req_addr >= DMEM_BYTES);
  assign req_err   = bad_op || bad_align || bad_range;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = req_err ? DONE : SETUP;
      SETUP:   nxt = RCLK;
      RCLK:    nxt = RHOLD;
      RHOLD:   nxt = is_st ? WCLK : DONE;
      WCLK:    nxt = WHOLD;
      WHOLD:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_err     <= 1'b0;
      is_st      <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      mem_op     <= '0;
      mem_we     <= 1'b0;
      mem_rdclk  <= 1'b0;
      mem_wrclk  <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= nxt;
      // Memory clocks come straight from flops so they cannot glitch.
      mem_rdclk <= (nxt == RCLK);
      mem_wrclk <= (nxt == WCLK);
      if (accept) begin
        mem_addr   <= req_addr;
        mem_datain <= req_wdata;
        mem_op     <= req_op;
        mem_we     <= req_we && !req_err;
        is_err     <= req_err;
        is_st      <= req_we && !req_err;
      end else if (nxt == DONE) begin
        mem_we <= 1'b0;
      end
      if (state == RHOLD && !is_st) resp_rdata <= mem_dataout;
      else if (state == DONE)       resp_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q  <= '0;
      st_q  <= '0;
      err_q <= '0;
    end else if (state == DONE) begin
      if (is_err)     begin if (err_q != 16'hFFFF) err_q <= err_q + 16'd1; end
      else if (is_st) begin if (st_q  != 16'hFFFF) st_q  <= st_q  + 16'd1; end
      else            begin if (ld_q  != 16'hFFFF) ld_q  <= ld_q  + 16'd1; end
    end
  end

endmodule

// File: tb/tb_dmem_seq.sv
// Bench for dmem_seq: behavioral dmem, response scoreboard and per-scenario tasks.
module tb_dmem_seq;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_op = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_datain, mem_dataout = '0;
  logic [2:0]  mem_op;
  logic        mem_we, mem_rdclk, mem_wrclk;
  logic [15:0] ld_cnt, st_cnt, err_cnt;

  dmem_seq #(.DMEM_BYTES(131072)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op), .req_we(req_we),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_op(mem_op), .mem_we(mem_we),
    .mem_rdclk(mem_rdclk), .mem_wrclk(mem_wrclk), .mem_dataout(mem_dataout),
    .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioral dmem: rdclk fetches and extends, wrclk merges into the fetched word.
  logic [31:0] mem [0:32767];
  logic [31:0] old_w;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] op, input logic [1:0] a);
    logic [7:0] b; logic [15:0] h;
    b = w[int'(a)*8 +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [2:0] op, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (op[1:0])
      2'b00:   r[int'(a)*8 +: 8] = d[7:0];
      2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge mem_rdclk) begin
    old_w = mem[mem_addr[16:2]];
    mem_dataout = ld_ext(old_w, mem_op, mem_addr[1:0]);
  end
  always @(posedge mem_wrclk) if (mem_we) mem[mem_addr[16:2]] = merge(old_w, mem_datain, mem_op, mem_addr[1:0]);

  typedef struct {logic err; logic [31:0] rdata; int lat; int nrd; int nwr;} exp_t;
  exp_t sb[$];
  int   acc_cnt = 0, last_acc = 0, prev_acc = 0, nrd = 0, nwr = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  // Monitor: pulse accounting, clock separation, scoreboard compare on resp_valid.
  always @(negedge clk) begin
    exp_t x;
    if (mem_rdclk) nrd++;
    if (mem_wrclk) nwr++;
    if (!reset) begin
      if (mem_rdclk || mem_wrclk) begin
        checks++;
        if ((mem_rdclk && mem_wrclk) || (prev_rd && mem_wrclk) || (prev_wr && mem_rdclk)) begin
          errors++; $display("FAIL clk_sep rd=%b wr=%b prev_rd=%b prev_wr=%b", mem_rdclk, mem_wrclk, prev_rd, prev_wr);
        end
      end
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_resp got resp_valid=1 expected none");
        end else begin
          x = sb.pop_front();
          if (resp_err !== x.err || resp_rdata !== x.rdata || (cyc + 1 - last_acc) != x.lat ||
              nrd != x.nrd || nwr != x.nwr) begin
            errors++;
            $display("FAIL resp got err=%b rdata=%h lat=%0d rd=%0d wr=%0d expected err=%b rdata=%h lat=%0d rd=%0d wr=%0d",
                     resp_err, resp_rdata, cyc + 1 - last_acc, nrd, nwr, x.err, x.rdata, x.lat, x.nrd, x.nwr);
          end
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++; prev_acc = last_acc; last_acc = cyc + 1; nrd = 0; nwr = 0;
      end
    end
    prev_rd = mem_rdclk; prev_wr = mem_wrclk;
  end

  function automatic exp_t mk_exp(input logic we, input logic e, input logic [31:0] rd);
    exp_t x;
    x.err = e; x.rdata = (e || we) ? 32'h0 : rd;
    x.lat = e ? 1 : (we ? 6 : 4);
    x.nrd = e ? 0 : 1; x.nwr = (!e && we) ? 1 : 0;
    return x;
  endfunction

  task automatic wait_resp();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL resp_timeout pending=%0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                       input logic we, input logic e, input logic [31:0] rd);
    int n = 0;
    @(posedge clk); #1;
    req_addr = a; req_wdata = d; req_op = op; req_we = we; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    sb.push_back(mk_exp(we, e, rd));
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0", req_ready, resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if ({mem_addr, mem_datain, mem_op, mem_we, mem_rdclk, mem_wrclk} !== 70'h0) begin
      errors++; $display("FAIL reset_mem addr=%h din=%h op=%b we=%b rd=%b wr=%b expected all 0", mem_addr, mem_datain, mem_op, mem_we, mem_rdclk, mem_wrclk);
    end
    checks++;
    if ({ld_cnt, st_cnt, err_cnt} !== 48'h0) begin
      errors++; $display("FAIL reset_cnt ld=%h st=%h err=%h expected 0", ld_cnt, st_cnt, err_cnt);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_load_word();
    mem[4] = 32'hDEADBEEF;
    issue(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 32'hDEADBEEF);
    checks++;
    if (ld_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt got %h expected 0001", ld_cnt); end
  endtask

  task automatic test_store_merge();
    issue(32'h13, 32'h5A, 3'b000, 1'b1, 1'b0, 32'h0);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h13 || mem_datain !== 32'h5A) begin
      errors++; $display("FAIL store_hold we=%b addr=%h din=%h expected 0 13 5a", mem_we, mem_addr, mem_datain);
    end
    checks++;
    if (st_cnt !== 16'd1) begin errors++; $display("FAIL st_cnt got %h expected 0001", st_cnt); end
    issue(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 32'h5AADBEEF);
  endtask

  task automatic test_extend();
    issue(32'h12, 32'h0, 3'b000, 1'b0, 1'b0, 32'hFFFFFFAD);
    issue(32'h12, 32'h0, 3'b100, 1'b0, 1'b0, 32'h000000AD);
    issue(32'h12, 32'h0, 3'b001, 1'b0, 1'b0, 32'h00005AAD);
    checks++;
    if (ld_cnt !== 16'd5) begin errors++; $display("FAIL ld_cnt_ext got %h expected 0005", ld_cnt); end
  endtask

  task automatic test_errors();
    issue(32'h11,    32'h0,        3'b001, 1'b0, 1'b1, 32'h0);
    issue(32'h0E,    32'h12345678, 3'b010, 1'b1, 1'b1, 32'h0);
    issue(32'h20000, 32'h0,        3'b010, 1'b0, 1'b1, 32'h0);
    issue(32'h10,    32'h0,        3'b111, 1'b0, 1'b1, 32'h0);
    checks++;
    if (err_cnt !== 16'd4) begin errors++; $display("FAIL err_cnt got %h expected 0004", err_cnt); end
    checks++;
    if (mem[4] !== 32'h5AADBEEF || mem[3] !== 32'h0) begin
      errors++; $display("FAIL err_mem got %h %h expected 5aadbeef 00000000", mem[4], mem[3]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mem[8] = 32'h11111111;
    @(posedge clk); #1;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_op = 3'b010; req_we = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    while (!mem_rdclk && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (mem_rdclk !== 1'b1) begin errors++; $display("FAIL mid_rclk got rdclk=%b expected 1", mem_rdclk); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_rdclk !== 1'b0 || mem_wrclk !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset ready=%b valid=%b rd=%b wr=%b we=%b expected 1 0 0 0 0", req_ready, resp_valid, mem_rdclk, mem_wrclk, mem_we);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (mem[8] !== 32'h11111111 || st_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_mem got mem=%h st=%h expected 11111111 0000", mem[8], st_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int s, n = 0;
    s = acc_cnt;
    @(posedge clk); #1;
    req_addr = 32'h10; req_op = 3'b010; req_we = 1'b0; req_valid = 1'b1;
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h5AADBEEF));
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h5AADBEEF));
    while (acc_cnt < s + 2 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp();
    checks++;
    if (acc_cnt != s + 2 || last_acc - prev_acc != 5) begin
      errors++; $display("FAIL b2b accepts=%0d gap=%0d expected 2 5", acc_cnt - s, last_acc - prev_acc);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.ld_q = 16'hFFFF;
    @(negedge clk);
    release dut.ld_q;
    issue(32'h10, 32'h0, 3'b010, 1'b0, 1'b0, 32'h5AADBEEF);
    checks++;
    if (ld_cnt !== 16'hFFFF) begin errors++; $display("FAIL ld_sat got %h expected ffff", ld_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_store_merge();
    test_extend();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time limit expected completion");
    $fatal(1);
  end
endmodule
